// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the unified memory.
// slave = arbiter view, master = requesters plus memory model view.
interface mem_arbiter_if #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_BURST_W = 4
);
  logic                   m0_req;
  logic                   m0_we;
  logic [ADDR_W-1:0]      m0_addr;
  logic [DATA_W-1:0]      m0_wdata;
  logic                   m0_gnt;
  logic                   m0_rvalid;
  logic [DATA_W-1:0]      m0_rdata;
  logic                   m1_req;
  logic                   m1_we;
  logic [ADDR_W-1:0]      m1_addr;
  logic [MAX_BURST_W-1:0] m1_len;
  logic [DATA_W-1:0]      m1_wdata;
  logic                   m1_gnt;
  logic                   m1_beat;
  logic                   m1_rvalid;
  logic [DATA_W-1:0]      m1_rdata;
  logic                   m1_done;
  logic [ADDR_W-1:0]      mem_A;
  logic [DATA_W-1:0]      mem_WD;
  logic                   mem_MemWrite;
  logic [DATA_W-1:0]      mem_RD;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_len, m1_wdata,
    output m1_gnt, m1_beat, m1_rvalid, m1_rdata, m1_done,
    output mem_A, mem_WD, mem_MemWrite,
    input  mem_RD
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_len, m1_wdata,
    input  m1_gnt, m1_beat, m1_rvalid, m1_rdata, m1_done,
    input  mem_A, mem_WD, mem_MemWrite,
    output mem_RD
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter: CPU single accesses vs DMA bursts on one memory port.
// Define MEM_ARB_STATS_EN to add saturating grant/beat counters.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_BURST_W = 4
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MEM_ARB_STATS_EN
  output logic [31:0] m0_grant_count,
  output logic [31:0] m1_beat_count,
`endif
  mem_arbiter_if.slave bus
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                 state_q, state_d;
  logic                   ptr_q, ptr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [MAX_BURST_W-1:0] cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      a_q, a_d;
  logic [DATA_W-1:0]      wd_q, wd_d;
  logic                   rv0_q, rv0_d;
  logic                   rv1_q, rv1_d;

  logic                   gnt0, gnt1, beat, done, mwe;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    a_d     = a_q;
    wd_d    = wd_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    beat    = 1'b0;
    done    = 1'b0;
    mwe     = 1'b0;
    unique case (state_q)
      IDLE: if (!reset) begin
        // pointer only breaks ties; a lone requester always wins
        gnt0 = bus.m0_req & ~(bus.m1_req & ptr_q);
        gnt1 = bus.m1_req & ~gnt0;
        if (bus.m0_req && bus.m1_req) ptr_d = ~ptr_q;
        if (gnt0) begin
          a_d   = bus.m0_addr;
          wd_d  = bus.m0_wdata;
          mwe   = bus.m0_we;
          rv0_d = ~bus.m0_we;
        end
        if (gnt1) begin
          addr_d  = bus.m1_addr;
          cnt_d   = bus.m1_len;
          we_d    = bus.m1_we;
          state_d = BURST;
        end
      end
      BURST: if (!reset) begin
        beat   = 1'b1;
        a_d    = addr_q;
        wd_d   = bus.m1_wdata;
        mwe    = we_q;
        rv1_d  = ~we_q;
        addr_d = addr_q + ADDR_W'(4);
        cnt_d  = cnt_q - MAX_BURST_W'(1);
        if (cnt_q == '0) begin
          done    = 1'b1;
          ptr_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      a_q     <= '0;
      wd_q    <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      a_q     <= a_d;
      wd_q    <= wd_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  assign bus.m0_gnt       = gnt0;
  assign bus.m1_gnt       = gnt1;
  assign bus.m1_beat      = beat;
  assign bus.m1_done      = done;
  assign bus.mem_A        = a_d;
  assign bus.mem_WD       = wd_d;
  assign bus.mem_MemWrite = mwe;
  // reset in flight kills a read return still on its way back
  assign bus.m0_rvalid    = rv0_q & ~reset;
  assign bus.m1_rvalid    = rv1_q & ~reset;
  assign bus.m0_rdata     = bus.m0_rvalid ? bus.mem_RD : '0;
  assign bus.m1_rdata     = bus.m1_rvalid ? bus.mem_RD : '0;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] g0cnt_q, b1cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      g0cnt_q <= '0;
      b1cnt_q <= '0;
    end else begin
      if (gnt0 && g0cnt_q != '1) g0cnt_q <= g0cnt_q + 32'd1;
      if (beat && b1cnt_q != '1) b1cnt_q <= b1cnt_q + 32'd1;
    end
  end

  assign m0_grant_count = g0cnt_q;
  assign m1_beat_count  = b1cnt_q;
`endif

endmodule
